// File: rtl/inc_seq_checker.sv
// Lock/error checker for a free-running incrementing data stream (mod 2^DATA_W).
// Optional build macro SEQ_CHK_REPEAT_OK_EN: tolerate a repeat of the previous sample.
module inc_seq_checker #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [DATA_W-1:0]    expected
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);

    logic [1:0]           state_q,     state_d;
    logic                 locked_q,    locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [DATA_W-1:0]    expected_q,  expected_d;
    logic [GOOD_W-1:0]    good_cnt_q,  good_cnt_d;

    logic match;
    logic repeat_ok;

    assign match = (in_data == expected_q);

`ifdef SEQ_CHK_REPEAT_OK_EN
    assign repeat_ok = (in_data == (expected_q - DATA_ONE));
`else
    assign repeat_ok = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        expected_d  = expected_q;
        good_cnt_d  = good_cnt_q;

        if (clear) begin
            state_d     = ST_IDLE;
            locked_d    = 1'b0;
            err_count_d = '0;
            expected_d  = '0;
            good_cnt_d  = '0;
        end else if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    expected_d = in_data + DATA_ONE;
                    good_cnt_d = GOOD_ONE;
                    state_d    = ST_ACQ;
                end
                ST_ACQ: begin
                    if (match) begin
                        expected_d = expected_q + DATA_ONE;
                        if (good_cnt_q + GOOD_ONE >= GOOD_LOCK) begin
                            good_cnt_d = GOOD_LOCK;
                            state_d    = ST_LOCKED;
                            locked_d   = 1'b1;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_ONE;
                        end
                    end else if (!repeat_ok) begin
                        expected_d = in_data + DATA_ONE;
                        good_cnt_d = GOOD_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        expected_d = expected_q + DATA_ONE;
                    end else if (!repeat_ok) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1)
                            err_count_d = err_count_q + ERR_CNT_W'(1);
                        locked_d   = 1'b0;
                        expected_d = in_data + DATA_ONE;
                        good_cnt_d = GOOD_ONE;
                        state_d    = ST_ACQ;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    locked_d   = 1'b0;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            expected_q  <= '0;
            good_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            expected_q  <= expected_d;
            good_cnt_q  <= good_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;

endmodule

// File: tb/tb_inc_seq_checker.sv
// Directed bench for inc_seq_checker; a second instance with ERR_CNT_W=2 covers saturation.
module tb_inc_seq_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;

    logic        locked,    s_locked;
    logic        err_pulse, s_err_pulse;
    logic [7:0]  err_count;
    logic [1:0]  s_err_count;
    logic [15:0] expected,  s_expected;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    inc_seq_checker #(.DATA_W(16), .LOCK_CNT(4), .ERR_CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .expected  (expected)
    );

    inc_seq_checker #(.DATA_W(16), .LOCK_CNT(4), .ERR_CNT_W(2)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (s_locked),
        .err_pulse (s_err_pulse),
        .err_count (s_err_count),
        .expected  (s_expected)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given sample; returns #1 after the edge so outputs can be checked.
    task automatic cycle(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic l, input logic p,
                             input logic [7:0] c, input logic [15:0] e);
        check({tag, "_locked"},    {31'd0, locked},    {31'd0, l});
        check({tag, "_err_pulse"}, {31'd0, err_pulse}, {31'd0, p});
        check({tag, "_err_count"}, {24'd0, err_count}, {24'd0, c});
        check({tag, "_expected"},  {16'd0, expected},  {16'd0, e});
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        check_out("reset", 1'b0, 1'b0, 8'd0, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;

        // Acquire lock on 0,1,2,3
        cycle(1'b1, 16'd0);
        check_out("acq0", 1'b0, 1'b0, 8'd0, 16'd1);
        cycle(1'b1, 16'd1);
        cycle(1'b1, 16'd2);
        check_out("acq2", 1'b0, 1'b0, 8'd0, 16'd3);
        cycle(1'b1, 16'd3);
        check_out("lock3", 1'b1, 1'b0, 8'd0, 16'd4);

        // Locked run then a skip: 4,5,6 then 8
        cycle(1'b1, 16'd4);
        cycle(1'b1, 16'd5);
        cycle(1'b1, 16'd6);
        check_out("run6", 1'b1, 1'b0, 8'd0, 16'd7);
        cycle(1'b1, 16'd8);
        check_out("skip8", 1'b0, 1'b1, 8'd1, 16'd9);
        cycle(1'b1, 16'd9);
        check_out("relock9", 1'b0, 1'b0, 8'd1, 16'd10);
        cycle(1'b1, 16'd10);
        cycle(1'b1, 16'd11);
        check_out("relock11", 1'b1, 1'b0, 8'd1, 16'd12);

        // Repeated sample while locked
        cycle(1'b1, 16'd12);
        cycle(1'b1, 16'd12);
`ifdef SEQ_CHK_REPEAT_OK_EN
        check_out("repeat", 1'b1, 1'b0, 8'd1, 16'd13);
`else
        check_out("repeat", 1'b0, 1'b1, 8'd2, 16'd13);
`endif

        // Idle cycle holds state, drops pulse
        cycle(1'b0, 16'hDEAD);
`ifdef SEQ_CHK_REPEAT_OK_EN
        check_out("hold", 1'b1, 1'b0, 8'd1, 16'd13);
`else
        check_out("hold", 1'b0, 1'b0, 8'd2, 16'd13);
`endif

        // Asynchronous reset mid-traffic
        cycle(1'b1, 16'd13);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 8'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 16'd100);
        check_out("post_rst", 1'b0, 1'b0, 8'd0, 16'd101);

        // Wrap through all-ones: FFFE reseeds in ACQ without an error
        cycle(1'b1, 16'hFFFE);
        check_out("wrap_fffe", 1'b0, 1'b0, 8'd0, 16'hFFFF);
        cycle(1'b1, 16'hFFFF);
        cycle(1'b1, 16'h0000);
        check_out("wrap_0000", 1'b0, 1'b0, 8'd0, 16'h0001);
        cycle(1'b1, 16'h0001);
        check_out("wrap_0001", 1'b1, 1'b0, 8'd0, 16'h0002);
        cycle(1'b1, 16'h0002);
        check_out("wrap_0002", 1'b1, 1'b0, 8'd0, 16'h0003);

        // Five lock/error rounds: 50 breaks lock, 51..53 relock
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'd50);
            check("sat_pulse", {31'd0, s_err_pulse}, 32'd1);
            cycle(1'b1, 16'd51);
            cycle(1'b1, 16'd52);
            cycle(1'b1, 16'd53);
        end
        check_out("five_err", 1'b1, 1'b0, 8'd5, 16'd54);
        check("sat_count", {30'd0, s_err_count}, 32'd3);
        check("sat_locked", {31'd0, s_locked}, 32'd1);

        // Clear wins over a valid sample in the same cycle
        clear = 1'b1;
        cycle(1'b1, 16'd54);
        clear = 1'b0;
        check_out("clear", 1'b0, 1'b0, 8'd0, 16'd0);
        check("clear_sat_count", {30'd0, s_err_count}, 32'd0);
        cycle(1'b1, 16'd7);
        check_out("after_clear", 1'b0, 1'b0, 8'd0, 16'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
